// File: rtl/intc_pkg.sv
// Interrupt controller shared definitions: source count, register map, STAT packing.
package intc_pkg;

  localparam int NUM_SRC = 6;

  localparam logic [1:0] PEND_A = 2'd0;
  localparam logic [1:0] MASK_A = 2'd1;
  localparam logic [1:0] EDGE_A = 2'd2;
  localparam logic [1:0] STAT_A = 2'd3;

  // OVF flags sit at this bit offset in the STAT word and in its clear mask
  localparam int OVF_OFS = 8;

  function automatic logic [31:0] stat_word(input logic [NUM_SRC-1:0] ovf,
                                            input logic [NUM_SRC-1:0] src);
    logic [31:0] w;
    w = '0;
    w[OVF_OFS +: NUM_SRC] = ovf;
    w[NUM_SRC-1:0]        = src;
    return w;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Register-bus bundle for the interrupt controller (single-cycle strobe, combinational read).
interface int_ctrl_if;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output we, output addr, output wdata, input rdata);
  modport slave  (input sel, input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/intc_sync.sv
// Parameterised-width two-flop synchronizer with asynchronous active-low reset.
module intc_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // two back-to-back flops; first stage may go metastable, second resolves it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: per-source edge/level capture, mask, overflow flags, CP0 lines.
// Build option: define INTC_SYNC_EN to put 2-flop synchronizers on irq_src; leave it
// undefined when the sources are already synchronous to clk.
import intc_pkg::*;

module int_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  int_ctrl_if.slave          bus,
  output logic [NUM_SRC-1:0] ext_int
);

  logic [NUM_SRC-1:0] src_s;
  logic               src_vld;
  logic [NUM_SRC-1:0] prev_s;
  logic [NUM_SRC-1:0] armed;
  logic [NUM_SRC-1:0] pend, pend_d;
  logic [NUM_SRC-1:0] ovf, ovf_d;
  logic [NUM_SRC-1:0] mask, mask_d;
  logic [NUM_SRC-1:0] edge_mode, edge_mode_d;
  logic [NUM_SRC-1:0] rise, w1c, ovf_clr, mode_chg;
  logic               wr;
  logic               unused_wdata;

`ifdef INTC_SYNC_EN
  logic [1:0] vld_sr;

  intc_sync #(.W(NUM_SRC)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_src),
    .q     (src_s)
  );

  // src_s only reflects the real inputs once both sync stages have loaded after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_sr <= '0;
    else        vld_sr <= {vld_sr[0], 1'b1};
  end

  assign src_vld = vld_sr[1];
`else
  assign src_s   = irq_src;
  assign src_vld = 1'b1;
`endif

  assign unused_wdata = ^{bus.wdata[31:OVF_OFS+NUM_SRC], bus.wdata[OVF_OFS-1:NUM_SRC]};

  // next-state for capture, overflow and config registers
  always_comb begin
    wr       = bus.sel & bus.we;
    // a source must be seen low after reset before its rise counts as an edge
    rise     = src_s & ~prev_s & armed;
    w1c      = (wr && bus.addr == PEND_A) ? bus.wdata[NUM_SRC-1:0] : '0;
    ovf_clr  = (wr && bus.addr == STAT_A) ? bus.wdata[OVF_OFS +: NUM_SRC] : '0;
    mode_chg = (wr && bus.addr == EDGE_A) ? (bus.wdata[NUM_SRC-1:0] ^ edge_mode) : '0;

    // edge: set beats W1C; level: follow the source; a mode flip wipes the bit
    pend_d = ((edge_mode & (rise | (pend & ~w1c))) | (~edge_mode & src_s)) & ~mode_chg;
    ovf_d  = ((edge_mode & rise & pend) | (ovf & ~ovf_clr)) & ~mode_chg;

    mask_d      = (wr && bus.addr == MASK_A) ? bus.wdata[NUM_SRC-1:0] : mask;
    edge_mode_d = (wr && bus.addr == EDGE_A) ? bus.wdata[NUM_SRC-1:0] : edge_mode;
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_s    <= '0;
      armed     <= '0;
      pend      <= '0;
      ovf       <= '0;
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      prev_s    <= src_s;
      armed     <= armed | (~src_s & {NUM_SRC{src_vld}});
      pend      <= pend_d;
      ovf       <= ovf_d;
      mask      <= mask_d;
      edge_mode <= edge_mode_d;
    end
  end

  // combinational read mux
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      PEND_A:  bus.rdata[NUM_SRC-1:0] = pend;
      MASK_A:  bus.rdata[NUM_SRC-1:0] = mask;
      EDGE_A:  bus.rdata[NUM_SRC-1:0] = edge_mode;
      default: bus.rdata = stat_word(ovf, src_s);
    endcase
  end

  assign ext_int = pend & mask;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: register table, directed corner sequences, random run
// against a vector-level behavioural model.
module tb_int_ctrl;
  import intc_pkg::*;

`ifdef INTC_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] irq_src;
  logic [5:0] ext_int;

  int_ctrl_if bus_if();

  int_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .irq_src (irq_src),
    .bus     (bus_if.slave),
    .ext_int (ext_int)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // model state: what software would see, plus source history for the sync delay
  logic [5:0] m_pend, m_ovf, m_mask, m_edg, m_prev, m_seen_low;
  logic [5:0] m_h0, m_h1;
  int         m_age;

  typedef struct {
    logic        do_wr;
    logic [1:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] m_src();
    return (LAT == 0) ? irq_src : m_h1;
  endfunction

  function automatic logic [31:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {26'b0, m_pend};
      2'd1:    return {26'b0, m_mask};
      2'd2:    return {26'b0, m_edg};
      default: return {18'b0, m_ovf, 2'b0, m_src()};
    endcase
  endfunction

  task automatic model_reset();
    m_pend = '0; m_ovf = '0; m_mask = '0; m_edg = '0; m_prev = '0;
    m_seen_low = '0; m_h0 = '0; m_h1 = '0; m_age = 0;
  endtask

  task automatic model_edge();
    logic [5:0] s, up, clr, oclr, flip;
    logic       w;
    s    = m_src();
    up   = s & ~m_prev & m_seen_low;
    w    = bus_if.sel & bus_if.we;
    clr  = (w && bus_if.addr == 2'd0) ? bus_if.wdata[5:0]  : 6'h00;
    oclr = (w && bus_if.addr == 2'd3) ? bus_if.wdata[13:8] : 6'h00;
    flip = (w && bus_if.addr == 2'd2) ? (bus_if.wdata[5:0] ^ m_edg) : 6'h00;
    m_ovf  = ((m_ovf & ~oclr) | (m_edg & up & m_pend)) & ~flip;
    m_pend = ((m_edg & ((m_pend & ~clr) | up)) | (~m_edg & s)) & ~flip;
    if (w && bus_if.addr == 2'd1) m_mask = bus_if.wdata[5:0];
    if (w && bus_if.addr == 2'd2) m_edg  = bus_if.wdata[5:0];
    if (m_age >= LAT) m_seen_low = m_seen_low | ~s;
    m_prev = s;
    m_h1   = m_h0;
    m_h0   = irq_src;
    m_age++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("ext_int_model", {26'b0, ext_int}, {26'b0, m_pend & m_mask});
    chk("rdata_model", bus_if.rdata, m_rd(bus_if.addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.sel = 1'b1; bus_if.we = 1'b1; bus_if.addr = a; bus_if.wdata = d;
    step();
    bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.wdata = '0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus_if.addr = a;
    #1;
    chk(name, bus_if.rdata, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.sel = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int hi, first;
    rst_n   = 1'b0;
    irq_src = '0;
    model_reset();
    do_reset();

    // register map after reset and write truncation
    vt[0] = '{1'b0, PEND_A, 32'h0,         32'h0,  "rst_pend"};
    vt[1] = '{1'b0, MASK_A, 32'h0,         32'h0,  "rst_mask"};
    vt[2] = '{1'b0, EDGE_A, 32'h0,         32'h0,  "rst_edge"};
    vt[3] = '{1'b0, STAT_A, 32'h0,         32'h0,  "rst_stat"};
    vt[4] = '{1'b1, MASK_A, 32'hFFFF_FFFF, 32'h3F, "mask_all"};
    vt[5] = '{1'b1, EDGE_A, 32'hABCD_0015, 32'h15, "edge_trunc"};
    vt[6] = '{1'b1, MASK_A, 32'h0000_0022, 32'h22, "mask_part"};
    vt[7] = '{1'b1, EDGE_A, 32'h0,         32'h0,  "edge_clr"};
    chk("rst_ext_int", {26'b0, ext_int}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      if (vt[i].do_wr) wr(vt[i].a, vt[i].d);
      rd_chk(vt[i].a, vt[i].exp, vt[i].name);
    end

    // single pulse in edge mode, then W1C
    do_reset();
    wr(EDGE_A, 32'h3F);
    wr(MASK_A, 32'h01);
    irq_src = 6'h01;
    step();
    irq_src = 6'h00;
    repeat (LAT) step();
    rd_chk(PEND_A, 32'h01, "edge_pend");
    chk("edge_ext", {26'b0, ext_int}, 32'h01);
    wr(PEND_A, 32'h01);
    chk("w1c_ext", {26'b0, ext_int}, 32'h00);

    // level mode: 5-cycle hold gives a 5-cycle ext_int window delayed by the sync
    do_reset();
    wr(MASK_A, 32'h04);
    irq_src = 6'h04;
    hi = 0; first = -1;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) irq_src = 6'h00;
      step();
      if (ext_int[2]) begin
        hi++;
        if (first < 0) first = i;
      end
    end
    chk("lvl_width", hi, 5);
    chk("lvl_delay", first, LAT);
    irq_src = 6'h04;
    repeat (LAT + 1) step();
    wr(PEND_A, 32'h04);
    chk("lvl_w1c_ignored", {26'b0, ext_int}, 32'h04);

    // two pulses without clear -> overflow; clearing OVF keeps PEND
    do_reset();
    wr(EDGE_A, 32'h3F);
    irq_src = 6'h20; step();
    irq_src = 6'h00; step();
    irq_src = 6'h20; step();
    irq_src = 6'h00;
    repeat (LAT + 1) step();
    rd_chk(PEND_A, 32'h20, "ovf_pend");
    rd_chk(STAT_A, 32'h2000, "ovf_set");
    wr(STAT_A, 32'h2000);
    rd_chk(STAT_A, 32'h0, "ovf_clr");
    rd_chk(PEND_A, 32'h20, "ovf_pend_kept");

    // W1C colliding with a fresh edge on the same source
    irq_src = 6'h02; step();
    irq_src = 6'h00;
    repeat (LAT + 1) step();
    rd_chk(PEND_A, 32'h22, "pend1_set");
    irq_src = 6'h02;
    repeat (LAT) step();
    wr(PEND_A, 32'h02);
    rd_chk(PEND_A, 32'h22, "set_wins");
    wr(PEND_A, 32'h02);
    rd_chk(PEND_A, 32'h20, "w1c_no_edge");
    irq_src = 6'h00;

    // masked pending source, then unmask
    do_reset();
    wr(EDGE_A, 32'h3F);
    irq_src = 6'h08; step();
    irq_src = 6'h00;
    repeat (LAT + 1) step();
    chk("masked_ext", {26'b0, ext_int}, 32'h0);
    rd_chk(PEND_A, 32'h08, "masked_pend");
    wr(MASK_A, 32'h3F);
    chk("unmask_ext", {26'b0, ext_int}, 32'h08);

    // asynchronous reset with everything pending, sources kept high afterwards
    do_reset();
    wr(EDGE_A, 32'h3F);
    wr(MASK_A, 32'h3F);
    irq_src = 6'h3F;
    repeat (LAT + 1) step();
    chk("all_pend_ext", {26'b0, ext_int}, 32'h3F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ext", {26'b0, ext_int}, 32'h0);
    rd_chk(PEND_A, 32'h0, "async_rst_pend");
    rd_chk(MASK_A, 32'h0, "async_rst_mask");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    wr(EDGE_A, 32'h3F);
    wr(MASK_A, 32'h3F);
    repeat (6) step();
    rd_chk(PEND_A, 32'h0, "no_spurious_edge");
    chk("no_spurious_ext", {26'b0, ext_int}, 32'h0);
    irq_src = 6'h00;
    repeat (LAT + 1) step();
    irq_src = 6'h3F;
    repeat (LAT + 1) step();
    chk("rearm_ext", {26'b0, ext_int}, 32'h3F);

    // random traffic against the model
    do_reset();
    irq_src = '0;
    for (int n = 0; n < 800; n++) begin
      irq_src = irq_src ^ (6'($urandom) & 6'($urandom));
      bus_if.addr = 2'($urandom);
      if ($urandom_range(0, 9) < 3) begin
        bus_if.sel   = 1'b1;
        bus_if.we    = ($urandom_range(0, 3) != 0);
        bus_if.wdata = $urandom;
      end else begin
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.wdata = '0;
      end
      step();
    end
    bus_if.sel = 1'b0;
    bus_if.we  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst_n  input  1  reset; one clock domain; reset is asynchronous and active-low.
REQ-003 SHALL have ports: irq_src  input  6  peripheral interrupt requests, asynchronous to clk.
REQ-004 SHALL have ports: sel  input  1  bus access strobe, single-cycle.
REQ-005 SHALL have ports: we  input  1  write when sel=1, read otherwise.
REQ-006 SHALL have ports: addr  input  2  register select: 0 PEND, 1 MASK, 2 EDGE, 3 STAT.
REQ-007 SHALL have ports: wdata  input  32  write data.
REQ-008 SHALL have ports: rdata  output  32  read data, combinational from addr; unused bits 0.
REQ-009 SHALL have ports: ext_int  output  6  interrupt lines to the CP0 hardware-interrupt inputs (IP7..IP2).

Function
REQ-010 SHALL pass each irq_src bit through a 2-flop synchronizer; sync output is named src_s.
REQ-011 SHALL use per-source trigger mode EDGE[i]: 1 = rising edge, 0 = level.
REQ-012 SHALL keep prev_s, a registered copy of src_s; a rising edge is src_s[i] & ~prev_s[i].
REQ-013 Edge mode: SHALL set PEND[i] on a rising edge and hold it until software clears it.
REQ-014 Edge mode: SHALL clear PEND[i] on a write to addr 0 with wdata[i]=1 (write-1-to-clear).
REQ-015 Edge mode: if set and clear of PEND[i] occur in the same cycle, set SHALL win.
REQ-016 Level mode: PEND[i] SHALL be loaded with src_s[i] every cycle, and W1C writes SHALL have no effect.
REQ-017 Overflow: a rising edge on source i while PEND[i]=1 (edge mode) SHALL set OVF[i].
REQ-018 OVF[i] SHALL clear on a write to addr 3 with wdata[8+i]=1; set SHALL win over a same-cycle clear.
REQ-019 ext_int SHALL equal PEND & MASK, driven combinationally from registers; no further pipeline stage.
REQ-020 Writes to MASK SHALL NOT alter PEND; a masked pending source SHALL assert ext_int in the cycle after MASK is set.
REQ-021 Latency SHALL be: irq_src rising before clock edge k gives PEND set after edge k+2 and ext_int high in the following cycle (synchronizer enabled).
REQ-022 Read map SHALL be:
  - addr 0: {26'b0, PEND}
  - addr 1: {26'b0, MASK}
  - addr 2: {26'b0, EDGE}
  - addr 3: {18'b0, OVF[13:8], 2'b0, src_s[5:0]}
REQ-023 Writes SHALL load wdata[5:0] into MASK (addr 1) and into EDGE (addr 2).
REQ-024 Changing EDGE[i] SHALL clear PEND[i] and OVF[i] in the same cycle, to avoid a stale mode crossover.

Reset
REQ-025 On rst_n low, the block SHALL asynchronously clear synchronizer flops, prev_s, PEND, OVF, MASK and EDGE to 0, giving ext_int=0 and rdata=0.
REQ-026 After rst_n deasserts, a source already high SHALL NOT register as an edge until it has fallen and risen again.

Configuration
REQ-027 Macro INTC_SYNC_EN:
  - Defined: 2-flop synchronizers are present and latency follows REQ-021.
  - Undefined: src_s is irq_src directly (for sources known to be clk-synchronous), PEND sets at edge k, and ext_int is high one cycle after the request.

Structure
REQ-028 Package intc_pkg SHALL hold:
  - NUM_SRC=6
  - address constants PEND_A=0, MASK_A=1, EDGE_A=2, STAT_A=3
  - OVF bit offset 8
REQ-029 A sub-module intc_sync (parameterised-width 2-flop synchronizer, async active-low reset) SHALL be instantiated once.

Verification
REQ-030 Bench SHALL cover: EDGE=0x3F, MASK=0x01, 1-cycle pulse on irq_src[0] -> PEND=0x01 after 3 edges and ext_int=0x01; W1C 0x01 to addr 0 -> ext_int=0x00.
REQ-031 Bench SHALL cover: EDGE=0x00, MASK=0x04, irq_src[2] held high 5 cycles -> ext_int[2] high for 5 cycles, delayed 2; W1C to addr 0 ignored.
REQ-032 Bench SHALL cover: edge mode, two pulses on irq_src[5] without clear -> PEND[5]=1 and STAT bit 13=1; write 0x2000 to addr 3 -> bit 13=0 and PEND[5] still 1.
REQ-033 Bench SHALL cover: W1C to PEND[1] in the same cycle as a new edge on src 1 -> PEND[1] remains 1.
REQ-034 Bench SHALL cover: source pending with MASK=0 -> ext_int=0; write MASK=0x3F -> ext_int=PEND next cycle.
REQ-035 Bench SHALL cover: assert rst_n low mid-operation with PEND=0x3F -> all outputs 0 immediately (asynchronous), and no spurious edge while sources stay high after release.
